// File: rtl/tm1638_frame_arbiter.sv
// tm1638_frame_arbiter
// Shares one TM1638 display between two frame sources. Sources offer a full
// frame (w_digit x 8 segments plus 8 LEDs) over valid/ready. A one-cycle ARB
// state grants one source round-robin. The accepted frame is then scanned
// digit by digit for hold_sweeps full sweeps before the next ARB cycle.

module tm1638_frame_arbiter #(
    parameter int clk_mhz      = 25,
    parameter int w_digit      = 8,
    parameter int dwell_cycles = clk_mhz * 1000,
    parameter int hold_sweeps  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   a_valid,
    input  logic [8*w_digit-1:0]   a_seg,
    input  logic [7:0]             a_led,
    output logic                   a_ready,

    input  logic                   b_valid,
    input  logic [8*w_digit-1:0]   b_seg,
    input  logic [7:0]             b_led,
    output logic                   b_ready,

    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit,
    output logic [7:0]             led,
    output logic                   owner,
    output logic                   frame_done
);

    localparam int IDX_W   = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int DWELL_W = $clog2(dwell_cycles + 1);
    localparam int SWEEP_W = $clog2(hold_sweeps + 1);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(w_digit - 1);
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(dwell_cycles - 1);
    localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(hold_sweeps - 1);

    // State and buffered frame
    logic [0:0]             r_state;
    logic [8*w_digit-1:0]   r_buf_seg;
    logic [7:0]             r_buf_led;
    logic                   r_owner;
    logic                   r_last_grant;   // 0 = A, 1 = B
    logic [IDX_W-1:0]       r_index;
    logic [DWELL_W-1:0]     r_dwell;
    logic [SWEEP_W-1:0]     r_sweep;

    // Decoded conditions
    logic                   w_in_arb;
    logic                   w_in_scan;
    logic                   w_grant_a;
    logic                   w_grant_b;
    logic                   w_last_dwell;
    logic                   w_last_digit;
    logic                   w_hold_done;
    logic [7:0]             w_cur_seg;
    logic [w_digit-1:0]     w_digit_sel;

    assign w_in_arb     = (r_state == ST_ARB);
    assign w_in_scan    = (r_state == ST_SCAN);
    assign w_last_dwell = (r_dwell == LAST_DWELL);
    assign w_last_digit = (r_index == LAST_IDX);
    assign w_hold_done  = (r_sweep == LAST_SWEEP);

    // Round-robin grant: on a tie the source that did not win last time wins;
    // a lone valid source always wins. Only meaningful in ARB.
    assign w_grant_a = w_in_arb && a_valid && (!b_valid || r_last_grant);
    assign w_grant_b = w_in_arb && b_valid && (!a_valid || !r_last_grant);

    // The state register already sits in ARB during reset, so ready is also
    // gated by rst_n to keep every output low while reset is held.
    assign a_ready = rst_n && w_grant_a;
    assign b_ready = rst_n && w_grant_b;

    // Select the segment byte and one-hot digit strobe for the current index
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs; otherwise a latch is inferred.
        w_cur_seg   = 8'h00;
        w_digit_sel = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_cur_seg      = r_buf_seg[8*i +: 8];
                w_digit_sel[i] = 1'b1;
            end
        end
    end

    assign abcdefgh   = w_in_scan ? w_cur_seg   : 8'h00;
    assign digit      = w_in_scan ? w_digit_sel : '0;
    assign frame_done = w_in_scan && w_last_dwell && w_last_digit;
    assign led        = r_buf_led;
    assign owner      = r_owner;

    // Sequencer: one ARB cycle, then dwell/index/sweep counting through SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            r_state <= ST_ARB;
            r_index <= '0;
            r_dwell <= '0;
            r_sweep <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_state <= ST_SCAN;
                    r_index <= '0;
                    r_dwell <= '0;
                    r_sweep <= '0;
                end
                default: begin
                    if (!w_last_dwell) begin
                        r_dwell <= r_dwell + DWELL_W'(1);
                    end else begin
                        r_dwell <= '0;
                        if (!w_last_digit) begin
                            r_index <= r_index + IDX_W'(1);
                        end else begin
                            r_index <= '0;
                            if (w_hold_done) begin
                                r_state <= ST_ARB;
                                r_sweep <= '0;
                            end else begin
                                r_sweep <= r_sweep + SWEEP_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Frame buffer, owner and round-robin history; loaded only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the frame buffer is a plain register bank (not a RAM), so it is reset to a blank frame.
            r_buf_seg    <= '0;
            r_buf_led    <= 8'h00;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant_a) begin
            r_buf_seg    <= a_seg;
            r_buf_led    <= a_led;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
        end else if (w_grant_b) begin
            r_buf_seg    <= b_seg;
            r_buf_led    <= b_led;
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
        end
    end

endmodule
